// File: rtl/btn_ctrl_pkg.sv
// Shared types and 100 MHz timing defaults for the push-button step sequencer.
package btn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      REPEAT  = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   // Without auto-repeat the single "waiting for release" state reuses the DELAY encoding.
   localparam state_t HELD = DELAY;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 50_000_000;
   localparam int DEF_REPEAT_RATE     = 10_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for one raw push-button.
module btn_debounce
   import btn_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised level disagrees with the debounced one.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = cnt_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_db = db_q;

endmodule

// File: rtl/button_step_ctrl.sv
// Turns two raw buttons into mutually exclusive single-cycle add/sub step pulses.
// Define BTN_AUTOREPEAT_EN for hold-to-auto-repeat; otherwise one pulse per press.
module button_step_ctrl
   import btn_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   output logic add,
   output logic sub,
   output logic active
);

   logic   db_up, db_down;
   logic   up_prev_q, up_prev_d;
   logic   down_prev_q, down_prev_d;
   logic   rise_up, rise_down;
   logic   held_db, other_db;
   logic   fire;
   state_t state_q, state_d;
   dir_t   dir_q, dir_d;
   logic   add_q, add_d;
   logic   sub_q, sub_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_up (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_up),
      .btn_db (db_up)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_down (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_down),
      .btn_db (db_down)
   );

`ifdef BTN_AUTOREPEAT_EN
   localparam int                 TIMER_W    = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(REPEAT_DELAY - 1);
   localparam logic [TIMER_W-1:0] RATE_LOAD  = TIMER_W'(REPEAT_RATE - 1);

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               timer_zero;

   assign timer_zero = (timer_q == '0);

   // A pulse from IDLE arms the initial hold delay; later pulses arm the repeat interval.
   always_comb begin
      timer_d = timer_q;
      if (fire) begin
         timer_d = (state_q == IDLE) ? DELAY_LOAD : RATE_LOAD;
      end else if (!timer_zero) begin
         timer_d = timer_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_repeat_param_range
   end
`endif

   // Lockout and release are checked before the timer so a release never yields a pulse.
   always_comb begin
      up_prev_d   = db_up;
      down_prev_d = db_down;
      rise_up     = db_up & ~up_prev_q;
      rise_down   = db_down & ~down_prev_q;
      held_db     = (dir_q == DIR_UP) ? db_up : db_down;
      other_db    = (dir_q == DIR_UP) ? db_down : db_up;
      state_d     = state_q;
      dir_d       = dir_q;
      fire        = 1'b0;
      case (state_q)
         IDLE: begin
            if (db_up && db_down) begin
               state_d = LOCKOUT;
            end else if (rise_up) begin
               dir_d   = DIR_UP;
               fire    = 1'b1;
               state_d = DELAY;
            end else if (rise_down) begin
               dir_d   = DIR_DN;
               fire    = 1'b1;
               state_d = DELAY;
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         DELAY, REPEAT: begin
            if (other_db) begin
               state_d = LOCKOUT;
            end else if (!held_db) begin
               state_d = IDLE;
            end else if (timer_zero) begin
               fire    = 1'b1;
               state_d = REPEAT;
            end
         end
`else
         HELD: begin
            if (other_db) begin
               state_d = LOCKOUT;
            end else if (!held_db) begin
               state_d = IDLE;
            end
         end
`endif
         LOCKOUT: begin
            if (!db_up && !db_down) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      add_d = fire && (dir_d == DIR_UP);
      sub_d = fire && (dir_d == DIR_DN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         dir_q       <= DIR_UP;
         add_q       <= 1'b0;
         sub_q       <= 1'b0;
         up_prev_q   <= 1'b0;
         down_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         add_q       <= add_d;
         sub_q       <= sub_d;
         up_prev_q   <= up_prev_d;
         down_prev_q <= down_prev_d;
      end
   end

   assign add    = add_q;
   assign sub    = sub_q;
   assign active = (state_q != IDLE) && (state_q != LOCKOUT);

endmodule
